// File: rtl/rail_phase_pkg.sv
// ---------------------------------------------------------------------------
// rail_phase_pkg
// Shared types and helpers for the rail12lp phase driver.
//   phase_state_t : sequencer states (idle, precharge, gap, evaluate, gap)
//   PRE_OFF_N     : gate level that turns a PFET pull-up off (active-low)
//   EVAL_OFF      : gate level that turns the NFET pull-down off
//   clamp_min1    : maps a requested phase length of 0 to 1 cycle
// ---------------------------------------------------------------------------
package rail_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_EVAL = 3'd3,
    ST_GAP2 = 3'd4
  } phase_state_t;

  localparam logic PRE_OFF_N = 1'b1;
  localparam logic EVAL_OFF  = 1'b0;

  // A phase can never be shorter than one cycle.
  function automatic int clamp_min1(input int cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/rail_phase_driver_if.sv
// ---------------------------------------------------------------------------
// rail_phase_driver_if
// Bundle between the control plane (master) and the phase driver (slave).
//   start_i, use_b_i, z_i          : control plane / array -> driver
//   busy_o, pre_a_n_o, pre_b_n_o,
//   eval_c_o, result_o,
//   result_vld_o, pre_fail_o       : driver -> control plane / array
// ---------------------------------------------------------------------------
interface rail_phase_driver_if;
  logic start_i;
  logic use_b_i;
  logic z_i;
  logic busy_o;
  logic pre_a_n_o;
  logic pre_b_n_o;
  logic eval_c_o;
  logic result_o;
  logic result_vld_o;
  logic pre_fail_o;

  modport master (
    output start_i, use_b_i, z_i,
    input  busy_o, pre_a_n_o, pre_b_n_o, eval_c_o,
           result_o, result_vld_o, pre_fail_o
  );

  modport slave (
    input  start_i, use_b_i, z_i,
    output busy_o, pre_a_n_o, pre_b_n_o, eval_c_o,
           result_o, result_vld_o, pre_fail_o
  );
endinterface

// File: rtl/rail_phase_cnt.sv
// ---------------------------------------------------------------------------
// rail_phase_cnt
// Loadable down-counter that times every phase of the sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value loaded (phase length - 1)
//   zero       : count has reached 0 (last cycle of the current phase)
// The counter rests at 0 when nothing reloads it.
// ---------------------------------------------------------------------------
module rail_phase_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/rail_phase_driver.sv
// ---------------------------------------------------------------------------
// rail_phase_driver
// Sequences the gates of a rail12lp dynamic parallel-pull-up node:
// precharge -> gap -> evaluate -> gap, then samples the node.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of rail_phase_driver_if
//     start_i      request a sequence (ignored while busy)
//     use_b_i      also enable pull-up B in precharge, latched at start
//     z_i          node read-back
//     busy_o       sequence in progress
//     pre_a_n_o    pull-up A gate (active low)
//     pre_b_n_o    pull-up B gate (active low)
//     eval_c_o     pull-down C gate (active high)
//     result_o     node value sampled on the last evaluate cycle
//     result_vld_o one-cycle pulse in the first cycle after evaluate
//     pre_fail_o   node was low at the end of precharge; sticky until the
//                  next accepted start
// All outputs come straight from flops. Every gate change goes through a
// state where all gates are off, so pull-up and pull-down never overlap.
// ---------------------------------------------------------------------------
module rail_phase_driver
  import rail_phase_pkg::*;
#(
  parameter int PRE_CYC  = 2,
  parameter int GAP_CYC  = 1,
  parameter int EVAL_CYC = 2,
  parameter int CNT_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  rail_phase_driver_if.slave bus
);

  // Counter reload values: phase length minus one, with 0 treated as 1.
  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(clamp_min1(PRE_CYC) - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(clamp_min1(GAP_CYC) - 1);
  localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(clamp_min1(EVAL_CYC) - 1);

  phase_state_t state_reg;
  logic         busy_reg;
  logic         pre_a_n_reg;
  logic         pre_b_n_reg;
  logic         eval_c_reg;
  logic         result_reg;
  logic         result_vld_reg;
  logic         pre_fail_reg;
  logic         use_b_reg;

  logic             cnt_load_next;
  logic [CNT_W-1:0] cnt_val_next;
  logic             cnt_zero;

  // The counter is reloaded on the edge that enters a new timed state, so
  // the new phase starts with its full length already in place.
  always_comb begin
    cnt_load_next = 1'b0;
    cnt_val_next  = '0;
    unique case (state_reg)
      ST_IDLE: begin
        cnt_load_next = bus.start_i;
        cnt_val_next  = PRE_LOAD;
      end
      ST_PRE: begin
        cnt_load_next = cnt_zero;
        cnt_val_next  = GAP_LOAD;
      end
      ST_GAP1: begin
        cnt_load_next = cnt_zero;
        cnt_val_next  = EVAL_LOAD;
      end
      ST_EVAL: begin
        cnt_load_next = cnt_zero;
        cnt_val_next  = GAP_LOAD;
      end
      default: begin
        cnt_load_next = 1'b0;
        cnt_val_next  = '0;
      end
    endcase
  end

  rail_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load_next),
    .load_val(cnt_val_next),
    .zero    (cnt_zero)
  );

  // Outputs are assigned on the edge that enters each state, so they are
  // valid in the first cycle of that state without any output decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      busy_reg       <= 1'b0;
      pre_a_n_reg    <= PRE_OFF_N;
      pre_b_n_reg    <= PRE_OFF_N;
      eval_c_reg     <= EVAL_OFF;
      result_reg     <= 1'b0;
      result_vld_reg <= 1'b0;
      pre_fail_reg   <= 1'b0;
      use_b_reg      <= 1'b0;
    end else begin
      result_vld_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_reg    <= ST_PRE;
            busy_reg     <= 1'b1;
            use_b_reg    <= bus.use_b_i;
            pre_fail_reg <= 1'b0;
            pre_a_n_reg  <= 1'b0;
            pre_b_n_reg  <= ~bus.use_b_i;
            eval_c_reg   <= EVAL_OFF;
          end
        end
        ST_PRE: begin
          if (cnt_zero) begin
            state_reg   <= ST_GAP1;
            pre_a_n_reg <= PRE_OFF_N;
            pre_b_n_reg <= PRE_OFF_N;
            // A node that did not charge is flagged but still evaluated.
            if (!bus.z_i) begin
              pre_fail_reg <= 1'b1;
            end
          end else begin
            pre_b_n_reg <= ~use_b_reg;
          end
        end
        ST_GAP1: begin
          if (cnt_zero) begin
            state_reg  <= ST_EVAL;
            eval_c_reg <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (cnt_zero) begin
            state_reg      <= ST_GAP2;
            eval_c_reg     <= EVAL_OFF;
            result_reg     <= bus.z_i;
            result_vld_reg <= 1'b1;
          end
        end
        ST_GAP2: begin
          if (cnt_zero) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          busy_reg    <= 1'b0;
          pre_a_n_reg <= PRE_OFF_N;
          pre_b_n_reg <= PRE_OFF_N;
          eval_c_reg  <= EVAL_OFF;
        end
      endcase
    end
  end

  assign bus.busy_o       = busy_reg;
  assign bus.pre_a_n_o    = pre_a_n_reg;
  assign bus.pre_b_n_o    = pre_b_n_reg;
  assign bus.eval_c_o     = eval_c_reg;
  assign bus.result_o     = result_reg;
  assign bus.result_vld_o = result_vld_reg;
  assign bus.pre_fail_o   = pre_fail_reg;

  // Pull-down on means both pull-ups off, in every cycle.
  a_no_overlap: assert property (@(posedge clk)
    eval_c_reg |-> (pre_a_n_reg && pre_b_n_reg));

  // Precharge always hands over to a gap, never straight to evaluate.
  a_no_pre_to_eval: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == ST_PRE) |=> (state_reg != ST_EVAL));

endmodule

// File: tb/tb_rail_phase_driver.sv
// ---------------------------------------------------------------------------
// tb_rail_phase_driver
// Drives two drivers with identical stimulus: one with default timing
// (2/1/2) and one with all phase lengths 0 (clamped to 1). Each is compared
// every cycle to a reference that tracks only "cycles since start" and
// derives the gate pattern from phase boundaries by arithmetic.
// Output vector order: {busy, pre_a_n, pre_b_n, eval_c, result, vld, fail}
// ---------------------------------------------------------------------------
module tb_rail_phase_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic use_b = 1'b0;
  logic z = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rail_phase_driver_if if0();
  rail_phase_driver_if if1();

  assign if0.start_i = start;
  assign if0.use_b_i = use_b;
  assign if0.z_i     = z;
  assign if1.start_i = start;
  assign if1.use_b_i = use_b;
  assign if1.z_i     = z;

  rail_phase_driver #(
    .PRE_CYC(2), .GAP_CYC(1), .EVAL_CYC(2), .CNT_W(4)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0)
  );

  rail_phase_driver #(
    .PRE_CYC(0), .GAP_CYC(0), .EVAL_CYC(0), .CNT_W(4)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  wire [6:0] obs0 = {if0.busy_o, if0.pre_a_n_o, if0.pre_b_n_o, if0.eval_c_o,
                     if0.result_o, if0.result_vld_o, if0.pre_fail_o};
  wire [6:0] obs1 = {if1.busy_o, if1.pre_a_n_o, if1.pre_b_n_o, if1.eval_c_o,
                     if1.result_o, if1.result_vld_o, if1.pre_fail_o};

  // ---------------- reference model ----------------
  // pos = index of the current cycle inside a sequence, -1 when idle.
  int   m_p[2];
  int   m_g[2];
  int   m_e[2];
  int   m_pos[2];
  logic m_useb[2];
  logic m_res[2];
  logic m_vld[2];
  logic m_fail[2];

  function automatic int len_of(input int cyc);
    return (cyc == 0) ? 1 : cyc;
  endfunction

  function automatic void model_edge(input int i);
    int total;
    total = m_p[i] + 2 * m_g[i] + m_e[i];
    if (!rst_n) begin
      m_pos[i] = -1; m_useb[i] = 0; m_res[i] = 0; m_vld[i] = 0; m_fail[i] = 0;
    end else begin
      m_vld[i] = 0;
      if (m_pos[i] < 0) begin
        if (start) begin
          m_pos[i] = 0; m_useb[i] = use_b; m_fail[i] = 0;
        end
      end else begin
        if (m_pos[i] == m_p[i] - 1 && !z) m_fail[i] = 1;
        if (m_pos[i] == m_p[i] + m_g[i] + m_e[i] - 1) begin
          m_res[i] = z; m_vld[i] = 1;
        end
        m_pos[i] = (m_pos[i] + 1 == total) ? -1 : m_pos[i] + 1;
      end
    end
  endfunction

  function automatic logic [6:0] exp_vec(input int i);
    logic in_seq, in_pre, in_eval;
    in_seq  = (m_pos[i] >= 0);
    in_pre  = in_seq && (m_pos[i] < m_p[i]);
    in_eval = (m_pos[i] >= m_p[i] + m_g[i]) && (m_pos[i] < m_p[i] + m_g[i] + m_e[i]);
    return {in_seq, !in_pre, !(in_pre && m_useb[i]), in_eval,
            m_res[i], m_vld[i], m_fail[i]};
  endfunction

  // One clock: both DUTs and both models advance, outputs then settle.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; start = 0;
    step(); step();
    if (obs0 !== 7'b0110000) begin
      errors++; $display("FAIL reset_dut0 got %b want %b", obs0, 7'b0110000);
    end
    checks++;
    if (obs1 !== 7'b0110000) begin
      errors++; $display("FAIL reset_dut1 got %b want %b", obs1, 7'b0110000);
    end
    checks++;
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    int busy_n = 0, vld_n = 0, preb_n = 0;
    logic res_seen = 1'b1;
    use_b = 1;
    for (int k = 0; k < 9; k++) begin
      start = (k == 0);
      z = (k < 3);
      step();
      if (obs0 !== exp_vec(0)) begin
        errors++; $display("FAIL basic cyc%0d got %b want %b", k, obs0, exp_vec(0));
      end
      checks++;
      busy_n += int'(if0.busy_o);
      vld_n  += int'(if0.result_vld_o);
      preb_n += int'(!if0.pre_b_n_o);
      if (if0.result_vld_o) res_seen = if0.result_o;
    end
    $display("basic: busy=%0d vld=%0d preb_low=%0d result=%b", busy_n, vld_n, preb_n, res_seen);
    if (busy_n !== 6) begin errors++; $display("FAIL basic_busy_len got %0d want 6", busy_n); end
    checks++;
    if (vld_n !== 1) begin errors++; $display("FAIL basic_vld_count got %0d want 1", vld_n); end
    checks++;
    if (preb_n !== 2) begin errors++; $display("FAIL basic_preb_low got %0d want 2", preb_n); end
    checks++;
    if (res_seen !== 1'b0) begin errors++; $display("FAIL basic_result got %b want 0", res_seen); end
    checks++;
    if (if0.pre_fail_o !== 1'b0) begin errors++; $display("FAIL basic_prefail got %b want 0", if0.pre_fail_o); end
    checks++;
  endtask

  task automatic test_no_b();
    int prea_n = 0, preb_n = 0;
    use_b = 0; z = 1;
    for (int k = 0; k < 9; k++) begin
      start = (k == 0);
      step();
      if (obs0 !== exp_vec(0)) begin
        errors++; $display("FAIL no_b cyc%0d got %b want %b", k, obs0, exp_vec(0));
      end
      checks++;
      prea_n += int'(!if0.pre_a_n_o);
      preb_n += int'(!if0.pre_b_n_o);
    end
    $display("no_b: prea_low=%0d preb_low=%0d", prea_n, preb_n);
    if (prea_n !== 2 || preb_n !== 0) begin
      errors++; $display("FAIL no_b_gates got a=%0d b=%0d want a=2 b=0", prea_n, preb_n);
    end
    checks++;
  endtask

  task automatic test_pre_fail();
    int vld_n = 0;
    use_b = 1'($urandom_range(0, 1)); z = 0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      step();
      if (obs0 !== exp_vec(0)) begin
        errors++; $display("FAIL pre_fail cyc%0d got %b want %b", k, obs0, exp_vec(0));
      end
      checks++;
      vld_n += int'(if0.result_vld_o);
    end
    $display("pre_fail: fail=%b vld=%0d", if0.pre_fail_o, vld_n);
    if (if0.pre_fail_o !== 1'b1 || vld_n !== 1) begin
      errors++; $display("FAIL pre_fail_sticky got fail=%b vld=%0d want fail=1 vld=1", if0.pre_fail_o, vld_n);
    end
    checks++;
    start = 1; z = 1;
    step();
    start = 0;
    if (if0.pre_fail_o !== 1'b0) begin
      errors++; $display("FAIL pre_fail_clear got %b want 0", if0.pre_fail_o);
    end
    checks++;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_ignored_start();
    int vld_n = 0, rises = 0;
    logic prev_busy = 1'b0;
    z = 1;
    for (int k = 0; k < 10; k++) begin
      start = (k == 0) || (k == 4);
      step();
      if (obs0 !== exp_vec(0)) begin
        errors++; $display("FAIL ignored cyc%0d got %b want %b", k, obs0, exp_vec(0));
      end
      checks++;
      vld_n += int'(if0.result_vld_o);
      if (if0.busy_o && !prev_busy) rises++;
      prev_busy = if0.busy_o;
    end
    $display("ignored_start: vld=%0d busy_rises=%0d", vld_n, rises);
    if (vld_n !== 1 || rises !== 1) begin
      errors++; $display("FAIL ignored_start got vld=%0d rises=%0d want 1 1", vld_n, rises);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int vld_n = 0, rises = 0;
    logic prev_busy = 1'b0;
    for (int k = 0; k < 28; k++) begin
      start = (k < 20);
      use_b = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      step();
      if (obs0 !== exp_vec(0)) begin
        errors++; $display("FAIL b2b cyc%0d got %b want %b", k, obs0, exp_vec(0));
      end
      checks++;
      vld_n += int'(if0.result_vld_o);
      if (if0.busy_o && !prev_busy) rises++;
      prev_busy = if0.busy_o;
    end
    $display("back_to_back: sequences=%0d vld=%0d", rises, vld_n);
    if (rises !== 3 || vld_n !== 3) begin
      errors++; $display("FAIL b2b_count got seq=%0d vld=%0d want 3 3", rises, vld_n);
    end
    checks++;
    start = 0;
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    int vld_n = 0;
    z = 1; use_b = 1; start = 1;
    step();
    start = 0;
    while (if0.eval_c_o !== 1'b1 && waited < 10) begin
      step(); waited++;
    end
    if (waited >= 10) begin
      errors++; $display("FAIL reset_mid_reach_eval got timeout want eval_c=1");
    end
    checks++;
    rst_n = 0;
    step();
    rst_n = 1;
    if (obs0 !== 7'b0110000) begin
      errors++; $display("FAIL reset_mid_abort got %b want %b", obs0, 7'b0110000);
    end
    checks++;
    for (int k = 0; k < 6; k++) begin
      step();
      vld_n += int'(if0.result_vld_o);
    end
    $display("reset_mid: vld_after_reset=%0d", vld_n);
    if (vld_n !== 0) begin
      errors++; $display("FAIL reset_mid_no_vld got %0d want 0", vld_n);
    end
    checks++;
  endtask

  task automatic test_min_cycles();
    int busy_n = 0, pre_n = 0, eval_n = 0;
    use_b = 1; z = 1;
    for (int k = 0; k < 7; k++) begin
      start = (k == 0);
      step();
      if (obs1 !== exp_vec(1)) begin
        errors++; $display("FAIL min_cyc cyc%0d got %b want %b", k, obs1, exp_vec(1));
      end
      checks++;
      busy_n += int'(if1.busy_o);
      pre_n  += int'(!if1.pre_a_n_o);
      eval_n += int'(if1.eval_c_o);
    end
    $display("min_cycles: busy=%0d pre=%0d eval=%0d", busy_n, pre_n, eval_n);
    if (busy_n !== 4 || pre_n !== 1 || eval_n !== 1) begin
      errors++; $display("FAIL min_cyc_len got busy=%0d pre=%0d eval=%0d want 4 1 1", busy_n, pre_n, eval_n);
    end
    checks++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      start = ($urandom_range(0, 3) == 0);
      use_b = 1'($urandom_range(0, 1));
      z = ($urandom_range(0, 5) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
      if (obs0 !== exp_vec(0)) begin
        errors++; bad++; $display("FAIL rand0 cyc%0d got %b want %b", k, obs0, exp_vec(0));
      end
      checks++;
      if (obs1 !== exp_vec(1)) begin
        errors++; bad++; $display("FAIL rand1 cyc%0d got %b want %b", k, obs1, exp_vec(1));
      end
      checks++;
    end
    rst_n = 1; start = 0;
    $display("random: 400 cycles, %0d mismatching cycles", bad);
  endtask

  initial begin
    m_p[0] = len_of(2); m_g[0] = len_of(1); m_e[0] = len_of(2);
    m_p[1] = len_of(0); m_g[1] = len_of(0); m_e[1] = len_of(0);
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1; m_useb[i] = 0; m_res[i] = 0; m_vld[i] = 0; m_fail[i] = 0;
    end
    test_reset();
    test_basic();
    test_no_b();
    test_pre_fail();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_min_cycles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
